regfile_write_port: RTL

- Write side of the 16x32 ARM-style register bank. Its read side is the 16:1 operand-select mux that feeds the ALU.
- Accepts write-back requests through a valid/ready handshake and buffers them in a small in-order FIFO.
- Decodes the 4-bit destination and commits one write per cycle into R0..R15.
- Drives all 16 registers to the read mux as a flat bus. Maintains R15 as the PC with auto-increment, and reports pending-write hazards per register.

---
 rtl/regfile_write_port.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/regfile_write_port.sv
// regfile_write_port
//
// Write side of the 16x32 register bank. Write-back requests enter through a
// valid/ready handshake and queue in a small in-order buffer. The head entry
// commits into R0..R15 on any edge where the buffer is non-empty and not
// stalled, with at most one commit per cycle. R15 doubles as the PC. A commit to
// R15 overrides pc_inc in the same cycle. Otherwise R15 advances by PC_STEP
// when pc_inc is high. regs_flat carries only committed state, with no bypass
// from the buffer.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   wr_valid   write request present
//   wr_ready   buffer has room (level != DEPTH)
//   wr_addr    destination register 0..15
//   wr_data    write data
//   stall      blocks the commit for this cycle
//   pc_inc     advance R15 by PC_STEP
//   regs_flat  Rn at bits [32n+31:32n]
//   pend_mask  bit n set while any buffered entry targets Rn
//   busy       buffer non-empty
//   level      buffered entry count, 0..DEPTH
//
// Parameters
//   DEPTH      write-buffer entries, 1..8
//   RESET_PC   R15 value after reset
//   PC_STEP    R15 increment per pc_inc cycle
//
// Build option
//   REGWR_ZERO_R0_EN  when defined, R0 reads as zero. Commits to R0 still pop
//                     the buffer but do not change R0, and pend_mask[0] stays 0.

module regfile_write_port #(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          PC_STEP  = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         wr_valid,
   output logic         wr_ready,
   input  logic [3:0]   wr_addr,
   input  logic [31:0]  wr_data,
   input  logic         stall,
   input  logic         pc_inc,
   output logic [511:0] regs_flat,
   output logic [15:0]  pend_mask,
   output logic         busy,
   output logic [3:0]   level
);

   localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0]        DEPTH_L  = 4'(DEPTH);
   localparam logic [31:0]       STEP_L   = 32'(PC_STEP);
   localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);

   logic [3:0]       fifo_addr [DEPTH];
   logic [31:0]      fifo_data [DEPTH];
   logic [DEPTH-1:0] fifo_vld;
   logic [DEPTH-1:0] fifo_vld_nxt;

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [3:0]       count;

   logic             push;
   logic             pop;
   logic [3:0]       head_addr;
   logic [31:0]      head_data;
   logic [15:0]      commit_we;

   logic [31:0]      regs [16];

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // ---------------------------------------------------------------------
   // Handshake and buffer control
   // ---------------------------------------------------------------------
   assign wr_ready  = (count != DEPTH_L);
   assign busy      = (count != 4'd0);
   assign level     = count;

   assign push      = wr_valid && wr_ready;
   assign pop       = busy && !stall;

   assign head_addr = fifo_addr[head];
   assign head_data = fifo_data[head];

   // When push and pop happen in the same cycle, the buffer is neither empty
   // nor full, so head and tail point at different slots and the two
   // valid-bit updates below do not collide.
   always_comb begin
      fifo_vld_nxt = fifo_vld;
      if (pop) begin
         fifo_vld_nxt[head] = 1'b0;
      end
      if (push) begin
         fifo_vld_nxt[tail] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head     <= '0;
         tail     <= '0;
         count    <= 4'd0;
         fifo_vld <= '0;
      end else begin
         fifo_vld <= fifo_vld_nxt;
         if (pop) begin
            head <= ptr_next(head);
         end
         if (push) begin
            tail <= ptr_next(tail);
         end
         case ({push, pop})
            2'b10:   count <= count + 4'd1;
            2'b01:   count <= count - 4'd1;
            default: count <= count;
         endcase
      end
   end

   // Payload storage needs no reset because the valid bits gate every use.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[tail] <= wr_addr;
         fifo_data[tail] <= wr_data;
      end
   end

   // ---------------------------------------------------------------------
   // Pending-write hazard mask
   // ---------------------------------------------------------------------
   always_comb begin
      pend_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (fifo_vld[i]) begin
            pend_mask[fifo_addr[i]] = 1'b1;
         end
      end
`ifdef REGWR_ZERO_R0_EN
      pend_mask[0] = 1'b0;
`endif
   end

   // ---------------------------------------------------------------------
   // Register bank
   // ---------------------------------------------------------------------
   always_comb begin
      commit_we = '0;
      if (pop) begin
         commit_we = 16'b1 << head_addr;
      end
`ifdef REGWR_ZERO_R0_EN
      commit_we[0] = 1'b0;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < 15; n++) begin
            regs[n] <= '0;
         end
         regs[15] <= RESET_PC;
      end else begin
         for (int n = 0; n < 15; n++) begin
            if (commit_we[n]) begin
               regs[n] <= head_data;
            end
         end
         // A committed write to the PC overrides the increment.
         if (commit_we[15]) begin
            regs[15] <= head_data;
         end else if (pc_inc) begin
            regs[15] <= regs[15] + STEP_L;
         end
      end
   end

   always_comb begin
      regs_flat = '0;
      for (int n = 0; n < 16; n++) begin
         regs_flat[32*n +: 32] = regs[n];
      end
   end

endmodule
